// File: rtl/reset_sequencer.sv
// CPU reset sequencer: power-on, button, DTR and watchdog reset sources.
// Holds the CPU in reset for a fixed time and records the reset cause.
module reset_sequencer #(
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned WDT_CYCLES  = 25000000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_btn_stb,
    input  logic       i_dtr,
    input  logic       i_wdt_en,
    input  logic       i_wdt_kick,
    output logic       o_cpu_rst,
    output logic [1:0] o_cause,
    output logic [7:0] o_reset_count
);

    localparam int unsigned HW =
        (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [31:0] WDT_LAST = 32'(WDT_CYCLES - 1);

    localparam logic [1:0] CAUSE_POR = 2'd0;
    localparam logic [1:0] CAUSE_BTN = 2'd1;
    localparam logic [1:0] CAUSE_DTR = 2'd2;
    localparam logic [1:0] CAUSE_WDT = 2'd3;

    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        DTR_WAIT = 2'd1,
        RUN      = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_next;
    logic [31:0] wdt_cnt;
    logic [31:0] wdt_next;
    logic [1:0]  cause_next;
    logic [7:0]  count_next;
    logic        bump;
    logic        wdt_expire;

    // Watchdog fires on its last count unless serviced in the same cycle.
    assign wdt_expire = (wdt_cnt == WDT_LAST) && i_wdt_en && !i_wdt_kick;

    // Next-state, hold/watchdog counter and cause selection.
    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        wdt_next   = '0;
        cause_next = o_cause;
        bump       = 1'b0;
        unique case (state)
            HOLD: begin
                if (i_dtr) begin
                    state_next = DTR_WAIT;
                    cause_next = CAUSE_DTR;
                    hold_next  = '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_next = RUN;
                end else begin
                    hold_next = hold_cnt + 1'b1;
                end
            end
            DTR_WAIT: begin
                if (!i_dtr) begin
                    state_next = HOLD;
                    hold_next  = '0;
                end
            end
            RUN: begin
                if (i_dtr) begin
                    state_next = DTR_WAIT;
                    cause_next = CAUSE_DTR;
                    bump       = 1'b1;
                end else if (i_btn_stb) begin
                    state_next = HOLD;
                    cause_next = CAUSE_BTN;
                    hold_next  = '0;
                    bump       = 1'b1;
                end else if (wdt_expire) begin
                    state_next = HOLD;
                    cause_next = CAUSE_WDT;
                    hold_next  = '0;
                    bump       = 1'b1;
                end else if (i_wdt_en && !i_wdt_kick) begin
                    wdt_next = wdt_cnt + 32'd1;
                end
            end
            default: begin
                state_next = HOLD;
                hold_next  = '0;
            end
        endcase
    end

    // Saturating count of resets taken from RUN.
    always_comb begin
        count_next = o_reset_count;
        if (bump && (o_reset_count != 8'hFF)) begin
            count_next = o_reset_count + 8'd1;
        end
    end

    // State and output registers; CPU reset follows the next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= HOLD;
            hold_cnt      <= '0;
            wdt_cnt       <= '0;
            o_cpu_rst     <= 1'b1;
            o_cause       <= CAUSE_POR;
            o_reset_count <= 8'd0;
        end else begin
            state         <= state_next;
            hold_cnt      <= hold_next;
            wdt_cnt       <= wdt_next;
            o_cpu_rst     <= (state_next != RUN);
            o_cause       <= cause_next;
            o_reset_count <= count_next;
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: POR, button, DTR, watchdog,
// priority, saturation and mid-hold reset.
module tb_reset_sequencer;

    logic       clk;
    logic       rst;
    logic       btn;
    logic       dtr;
    logic       wdt_en;
    logic       kick;
    logic       cpu_rst;
    logic [1:0] cause;
    logic [7:0] count;

    int checks;
    int fails;
    int n;

    reset_sequencer #(
        .HOLD_CYCLES(16),
        .WDT_CYCLES (100)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_btn_stb    (btn),
        .i_dtr        (dtr),
        .i_wdt_en     (wdt_en),
        .i_wdt_kick   (kick),
        .o_cpu_rst    (cpu_rst),
        .o_cause      (cause),
        .o_reset_count(count)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Counts consecutive cycles with cpu reset high, bounded.
    task automatic hold_len(output int len);
        len = 0;
        while (cpu_rst === 1'b1 && len < 200) begin
            len++;
            tick();
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rst    = 1'b1;
        btn    = 1'b0;
        dtr    = 1'b0;
        wdt_en = 1'b0;
        kick   = 1'b0;

        // Power-on reset.
        repeat (3) tick();
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_cause", 32'(cause), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        rst = 1'b0;
        hold_len(n);
        check("por_hold_len", n, 16);
        check("por_cause", 32'(cause), 32'd0);
        check("por_count", 32'(count), 32'd0);

        // Button reset; a second press mid-hold is ignored.
        btn = 1'b1;
        tick();
        btn = 1'b0;
        check("btn_rst_next", 32'(cpu_rst), 32'd1);
        n = 0;
        while (cpu_rst === 1'b1 && n < 200) begin
            n++;
            btn = (n == 5);
            tick();
        end
        btn = 1'b0;
        check("btn_hold_len", n, 16);
        check("btn_cause", 32'(cause), 32'd1);
        check("btn_count", 32'(count), 32'd1);

        // DTR held for 40 cycles, then 16 hold cycles.
        dtr = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (cpu_rst === 1'b1) n++;
        end
        dtr = 1'b0;
        check("dtr_high_cycles", n, 40);
        check("dtr_cause", 32'(cause), 32'd2);
        wdt_en = 1'b1;
        tick();
        hold_len(n);
        check("dtr_hold_len", n, 16);
        check("dtr_count", 32'(count), 32'd2);

        // Unserviced watchdog fires 100 cycles into RUN.
        n = 0;
        while (cpu_rst === 1'b0 && n < 500) begin
            tick();
            n++;
        end
        check("wdt_timeout", n, 100);
        check("wdt_cause", 32'(cause), 32'd3);
        check("wdt_count", 32'(count), 32'd3);
        hold_len(n);
        check("wdt_hold_len", n, 16);

        // Kicks every 50 cycles keep the CPU running.
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            kick = ((i % 50) == 49);
            tick();
            if (cpu_rst !== 1'b0) n++;
        end
        kick = 1'b0;
        check("wdt_kick50_no_rst", n, 0);

        // Kick exactly on the expiry cycle suppresses the reset.
        n = 0;
        for (int j = 0; j < 100; j++) begin
            kick = (j == 99);
            tick();
            if (cpu_rst !== 1'b0) n++;
        end
        kick = 1'b0;
        repeat (5) begin
            tick();
            if (cpu_rst !== 1'b0) n++;
        end
        check("wdt_kick_on_expiry", n, 0);
        check("wdt_kick_count", 32'(count), 32'd3);
        wdt_en = 1'b0;

        // Button and DTR together: DTR wins.
        btn = 1'b1;
        dtr = 1'b1;
        tick();
        btn = 1'b0;
        dtr = 1'b0;
        check("simul_rst", 32'(cpu_rst), 32'd1);
        check("simul_cause", 32'(cause), 32'd2);
        check("simul_count", 32'(count), 32'd4);
        hold_len(n);
        check("simul_len", n, 17);

        // DTR arriving during a button hold retags cause, no recount.
        btn = 1'b1;
        tick();
        btn = 1'b0;
        repeat (3) tick();
        check("hold_btn_cause", 32'(cause), 32'd1);
        dtr = 1'b1;
        repeat (2) tick();
        dtr = 1'b0;
        check("hold_dtr_cause", 32'(cause), 32'd2);
        check("hold_dtr_count", 32'(count), 32'd5);
        hold_len(n);
        check("hold_dtr_len", n, 17);

        // Saturation after many button resets.
        for (int k = 0; k < 300; k++) begin
            btn = 1'b1;
            tick();
            btn = 1'b0;
            hold_len(n);
        end
        check("sat_count", 32'(count), 32'd255);
        check("sat_cause", 32'(cause), 32'd1);

        // Reset mid-hold, with DTR asserted, returns to reset values.
        btn = 1'b1;
        tick();
        btn = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        dtr = 1'b1;
        tick();
        check("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("midrst_cause", 32'(cause), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        rst = 1'b0;
        dtr = 1'b0;
        hold_len(n);
        check("midrst_hold_len", n, 16);
        check("midrst_cause_after", 32'(cause), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 16: number of cycles o_cpu_rst is held after a reset trigger (legal range 1..65535).
REQ-002 Parameter WDT_CYCLES, default 25000000: watchdog timeout in cycles, 1 s at 25 MHz (legal range 2..2^32-1).
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  reset, synchronous and active-high.
REQ-005 i_btn_stb  input  1  single-cycle reset-button press strobe, already synchronised.
REQ-006 i_dtr  input  1  DTR reset request level, already synchronised and minimum-width qualified.
REQ-007 i_wdt_en  input  1  watchdog enable level from CPU GPIO.
REQ-008 i_wdt_kick  input  1  single-cycle watchdog service strobe from CPU.
REQ-009 o_cpu_rst  output  1  registered reset to CPU, active-high.
REQ-010 o_cause  output  2  cause of the most recent reset: 0 POR, 1 BTN, 2 DTR, 3 WDT.
REQ-011 o_reset_count  output  8  saturating count of non-POR resets since i_rst.

Function
REQ-012 The FSM SHALL have exactly three states: HOLD (counting reset hold), DTR_WAIT (reset held while i_dtr high), and RUN (CPU released).
REQ-013 In HOLD, the hold counter SHALL increment each cycle; on the cycle it equals HOLD_CYCLES-1, the FSM SHALL go to RUN.
REQ-014 o_cpu_rst SHALL be registered and equal 1 in every cycle the FSM is in HOLD or DTR_WAIT, and 0 in RUN.
REQ-015 In RUN, the trigger priority SHALL be DTR > BTN > WDT, evaluated once per cycle.
REQ-016 In RUN with i_dtr=1: next state SHALL be DTR_WAIT, o_cause<=2.
REQ-017 In RUN with i_dtr=0 and i_btn_stb=1: next state SHALL be HOLD, o_cause<=1, hold counter<=0.
REQ-018 In RUN with watchdog expiry and no higher-priority trigger: next state SHALL be HOLD, o_cause<=3, hold counter<=0.
REQ-019 A trigger sampled in cycle t SHALL assert o_cpu_rst from cycle t+1; for BTN/WDT it SHALL stay asserted exactly HOLD_CYCLES cycles.
REQ-020 DTR_WAIT SHALL persist while i_dtr=1; in the first cycle with i_dtr=0, next state SHALL be HOLD with hold counter<=0.
REQ-021 While in HOLD, i_btn_stb SHALL be ignored.
REQ-022 While in HOLD, i_dtr=1 SHALL move the FSM to DTR_WAIT and set o_cause<=2, with no extra count increment if already counted.
REQ-023 o_reset_count SHALL increment by 1 on each RUN->HOLD or RUN->DTR_WAIT transition, saturating at 255.
REQ-024 Watchdog counter (32 bit) SHALL count only in RUN with i_wdt_en=1.
REQ-025 The watchdog counter SHALL clear on i_wdt_kick, when i_wdt_en=0, and in any state other than RUN.
REQ-026 Watchdog expiry SHALL be counter==WDT_CYCLES-1 with i_wdt_en=1 and i_wdt_kick=0; a kick in the same cycle SHALL suppress expiry.
REQ-027 The hold counter SHALL be wide enough for HOLD_CYCLES and SHALL never wrap: it stops at the transition to RUN.
REQ-028 o_cause SHALL change only on a transition into HOLD or DTR_WAIT from RUN, on REQ-022, or on i_rst.

Reset
REQ-029 While i_rst=1: state<=HOLD, hold counter<=0, watchdog counter<=0, o_cpu_rst<=1, o_cause<=0, o_reset_count<=0.
REQ-030 After i_rst deasserts, o_cpu_rst SHALL remain 1 for exactly HOLD_CYCLES further cycles (POR hold).
REQ-031 i_rst asserted in any state (mid-hold, DTR_WAIT, RUN) SHALL take effect on the next edge, overriding all triggers.

Verification
REQ-032 POR: i_rst=1 for 3 cycles, then 0, with HOLD_CYCLES=16 -> o_cpu_rst=1 for 16 cycles after release, then 0; o_cause=0; o_reset_count=0.
REQ-033 Button: in RUN, pulse i_btn_stb at cycle t -> o_cpu_rst=1 over cycles t+1..t+16, 0 at t+17; o_cause=1; o_reset_count=1; second pulse during hold has no effect.
REQ-034 DTR: in RUN, i_dtr=1 for 40 cycles -> o_cpu_rst=1 throughout plus 16 cycles after i_dtr falls; o_cause=2; count +1 only.
REQ-035 Watchdog (WDT_CYCLES=100): i_wdt_en=1 with no kicks -> reset 100 cycles after entering RUN, o_cause=3; kicking every 50 cycles -> no reset for 1000 cycles; kick on the expiry cycle -> no reset.
REQ-036 Simultaneous: i_btn_stb=1 and i_dtr=1 in the same RUN cycle -> DTR_WAIT, o_cause=2, count +1.
REQ-037 Saturation and mid-op reset: 300 button resets -> o_reset_count=255; then i_rst during HOLD -> all outputs at reset values next cycle.
